// File: rtl/dma_mem_if.sv
// Bus bundle between a DMA initiator (master) and the memory responder (slave):
// read/write request channels, read beat channel, write beat channel and error flag.
interface dma_mem_if #(
  parameter int DATA_WIDTH = 32
);
  logic [31:0]           rd_req_addr;
  logic [4:0]            rd_req_len;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [DATA_WIDTH-1:0] rd_rdata;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_ready;
  logic [31:0]           wr_req_addr;
  logic [4:0]            wr_req_len;
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_last;
  logic                  wr_ready;
  logic                  err;

  modport master (
    output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
    output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
    input  rd_req_ready, rd_rdata, rd_valid, rd_last,
    input  wr_req_ready, wr_ready, err
  );

  modport slave (
    input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
    input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
    output rd_req_ready, rd_rdata, rd_valid, rd_last,
    output wr_req_ready, wr_ready, err
  );
endinterface

// File: rtl/dma_mem_responder.sv
// Single-ported burst memory responder serving one read or write burst at a time.
// Optional protocol/range checking is enabled by defining DMA_RESP_ERR_CHECK_EN.
module dma_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input logic     clk,
  input logic     rst,
  dma_mem_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      idx_reg;
  logic [5:0]            beats_reg;
  logic                  last_wr_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  rd_grant, wr_grant;
  logic                  rd_beat_hs, wr_beat_hs, wr_end, last_beat;
  logic [IDX_W-1:0]      req_idx, rd_idx;
  logic [5:0]            req_beats;
  logic                  rd_load;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.rd_req_addr, bus.wr_req_addr};

  // A read wins a tie only when the previous grant went to a write.
  always_comb begin
    rd_grant = (state_reg == IDLE) && bus.rd_req_valid && (!bus.wr_req_valid || last_wr_reg);
    wr_grant = (state_reg == IDLE) && bus.wr_req_valid && !rd_grant;
  end

  assign req_idx    = rd_grant ? bus.rd_req_addr[IDX_W+1:2] : bus.wr_req_addr[IDX_W+1:2];
  assign req_beats  = {1'b0, (rd_grant ? bus.rd_req_len : bus.wr_req_len)} + 6'd1;
  assign last_beat  = (beats_reg == 6'd1);
  assign rd_beat_hs = (state_reg == RD_BURST) && bus.rd_ready;
  assign wr_beat_hs = (state_reg == WR_BURST) && bus.wr_valid;
  assign wr_end     = wr_beat_hs && (bus.wr_last || last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (rd_grant)      state_next = RD_BURST;
        else if (wr_grant) state_next = WR_BURST;
      end
      RD_BURST: if (rd_beat_hs && last_beat) state_next = IDLE;
      WR_BURST: if (wr_end)                  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_req_ready = rd_grant;
    bus.wr_req_ready = wr_grant;
    bus.rd_valid     = (state_reg == RD_BURST);
    bus.rd_last      = (state_reg == RD_BURST) && last_beat;
    bus.wr_ready     = (state_reg == WR_BURST);
    bus.rd_rdata     = rdata_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg     <= '0;
      beats_reg   <= '0;
      last_wr_reg <= 1'b1;
    end else if (rd_grant || wr_grant) begin
      idx_reg     <= req_idx;
      beats_reg   <= req_beats;
      last_wr_reg <= wr_grant;
    end else if (rd_beat_hs || wr_beat_hs) begin
      idx_reg     <= idx_reg + IDX_W'(1);
      beats_reg   <= beats_reg - 6'd1;
    end
  end

  // Read port prefetches the next word so beats stream without bubbles.
  assign rd_load = rd_grant || (rd_beat_hs && !last_beat);
  assign rd_idx  = rd_grant ? req_idx : idx_reg + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata_reg <= '0;
    else if (rd_load) rdata_reg <= mem[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_beat_hs) mem[idx_reg] <= bus.wr_data;
  end

`ifdef DMA_RESP_ERR_CHECK_EN
  logic err_reg;
  logic wr_last_bad, misaligned;

  assign wr_last_bad = wr_beat_hs && (bus.wr_last != last_beat);
  assign misaligned  = (rd_grant && (bus.rd_req_addr[1:0] != 2'b00)) ||
                       (wr_grant && (bus.wr_req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            err_reg <= 1'b0;
    else if (wr_last_bad || misaligned) err_reg <= 1'b1;
  end

  assign bus.err = err_reg;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: doc/dma_mem_responder.md
DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 32, width of the data beat.
- MEM_WORDS, 1024, depth of the internal word array; power of two.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- rd_req_addr, in, 32, read burst byte address.
- rd_req_len, in, 5, read burst beats minus 1.
- rd_req_valid, in, 1, read request valid.
- rd_req_ready, out, 1, read request accepted.
- rd_rdata, out, DATA_WIDTH, read beat data.
- rd_valid, out, 1, read beat valid.
- rd_last, out, 1, final read beat.
- rd_ready, in, 1, initiator accepts the read beat.
- wr_req_addr, in, 32, write burst byte address.
- wr_req_len, in, 5, write burst beats minus 1.
- wr_req_valid, in, 1, write request valid.
- wr_req_ready, out, 1, write request accepted.
- wr_data, in, DATA_WIDTH, write beat data.
- wr_valid, in, 1, write beat valid.
- wr_last, in, 1, initiator marks the final write beat.
- wr_ready, out, 1, responder accepts the write beat.
- err, out, 1, sticky protocol/range error flag.

Function
REQ-004 States: IDLE, RD_BURST, WR_BURST. Only one burst is in flight at a time.
REQ-005 In IDLE, rd_req_ready and wr_req_ready are combinational. At most one is high, and only when its own valid is high.
REQ-006 Simultaneous rd_req_valid and wr_req_valid in IDLE: grant goes to the opposite of the last granted type. After reset the last grant counts as write, so read wins first.
REQ-007 Request handshake (valid&&ready): latch word index = addr[31:2] mod MEM_WORDS, and beat count = len+1 (1..32). Then go to RD_BURST or WR_BURST.
REQ-008 RD_BURST
- rd_valid rises exactly 1 cycle after the request handshake, carrying mem[index].
- While rd_valid&&!rd_ready, rd_rdata/rd_valid/rd_last hold stable.
- On each rd_valid&&rd_ready the next beat is presented the following cycle, with no bubbles when rd_ready stays high.
- rd_last = 1 only on the final beat.
- After the final handshake: rd_valid = 0, return to IDLE.
REQ-009 WR_BURST
- wr_ready = 1 throughout.
- Each wr_valid&&wr_ready writes wr_data to mem[index], then increments index.
- The burst ends on the first beat where wr_last=1 or where the count is exhausted; then return to IDLE.
REQ-010 The index increments modulo MEM_WORDS. A burst crossing the top wraps to word 0.
REQ-011 Ready from IDLE: the cycle after burst end. Minimum gap between bursts is 1 cycle.
REQ-012 Read-after-write to the same word in consecutive bursts returns the newly written data.

Reset
REQ-013 Reset values:
- State = IDLE.
- rd_req_ready = 0, wr_req_ready = 0.
- rd_valid = 0, rd_last = 0, wr_ready = 0.
- rd_rdata = 0.
- err = 0.
- Last grant = write.
REQ-014 Reset mid-burst aborts the burst immediately. Beats already written remain in memory; memory contents are never cleared by reset.

Configuration
REQ-015 Macro DMA_RESP_ERR_CHECK_EN.
- Defined: err sets and stays set until reset on any of:
  - wr_last on a beat other than beat len+1.
  - wr_last absent on beat len+1.
  - A request with addr[1:0] != 0.
- Not defined: err is tied 0. Burst termination per REQ-009 is unchanged.

Verification
REQ-016 Write then read:
- Stimulus: write burst addr 0x100, len 7, data 0..7; then read addr 0x100, len 7, rd_ready=1.
- Response: rd_rdata 0..7 on 8 consecutive cycles, rd_last on the 8th, rd_valid first high 1 cycle after rd_req handshake.
REQ-017 Read backpressure:
- Stimulus: read len 3 with rd_ready toggling 1,0,1,0.
- Response: each beat held stable while rd_ready=0; exactly 4 handshakes; rd_last only on the 4th.
REQ-018 Simultaneous requests:
- Stimulus: rd_req_valid and wr_req_valid both high from reset, held.
- Response: grants alternate read, write, read; never both ready in one cycle.
REQ-019 Wrap-around:
- Stimulus: MEM_WORDS=1024, write addr 0xFF8 (word 1022), len 3, data A,B,C,D.
- Response: mem[1022]=A, mem[1023]=B, mem[0]=C, mem[1]=D.
REQ-020 Early last:
- Stimulus: write len 7 with wr_last on beat 3.
- Response: burst ends after beat 3; wr_req_ready available the next cycle; err=1 with DMA_RESP_ERR_CHECK_EN, err=0 without.
REQ-021 Reset mid-read:
- Stimulus: assert rst during beat 4 of a len-7 read.
- Response: rd_valid=0 immediately; state IDLE; a following read of the same address returns the unchanged data.
